// File: rtl/xosera_bus_sync_pkg.sv
// xv: shared bus-interface constants and types for the Xosera bus front end.
// Holds the pin polarity constants, the access FSM state type and the
// default sizing used by xosera_bus_sync and its synchronizer.
package xv;

    // Chip select is active low on the 68k-style bus.
    localparam logic CS_ENABLED = 1'b0;
    // rd_nwr = 1 means the host is reading a register.
    localparam logic RnW_READ   = 1'b1;

    // Default synchronizer depth and CS settle time (synchronized clocks).
    localparam int BUS_SYNC_STAGES_DEF = 2;
    localparam int BUS_SETTLE_DEF      = 1;

    // Settle counter width; SETTLE_CYCLES tops out at 7, so it loads at most 6.
    localparam int BUS_SETTLE_CNT_W    = 3;

    // Bus access FSM states.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        SETTLE       = 2'd1,
        COMMIT       = 2'd2,
        WAIT_RELEASE = 2'd3
    } bus_state_t;

    // Value loaded into the settle counter on entry to SETTLE.
    function automatic logic [BUS_SETTLE_CNT_W-1:0] settle_load(input int cycles);
        return BUS_SETTLE_CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/xosera_bus_sync_ff.sv
// xosera_sync_ff: N-stage single-bit synchronizer with a configurable reset
// value, used to bring the asynchronous bus control pins into pclk.
module xosera_sync_ff #(
    parameter int   N       = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [N-1:0] chain;

    // Shift the asynchronous input through N flops; the oldest stage is the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {N{RST_VAL}};
        end else begin
            chain <= {chain[N-2:0], d};
        end
    end

    assign q = chain[N-1];

endmodule

// File: rtl/xosera_bus_sync.sv
// xosera_bus_sync: moves the asynchronous 68k-style bus pins into the pclk
// domain and turns each chip-select assertion into exactly one single-cycle
// read or write strobe, with register number, byte select and data latched
// alongside it.
//
// Optional build macro BUS_RELEASE_FILTER_EN: when defined, the FSM needs two
// consecutive deasserted CS samples to leave WAIT_RELEASE, so a one-sample
// deassert glitch during a held access cannot start a second access.
module xosera_bus_sync
    import xv::*;
#(
    parameter int SYNC_STAGES   = BUS_SYNC_STAGES_DEF,
    parameter int SETTLE_CYCLES = BUS_SETTLE_DEF
) (
    input  logic       clk,
    input  logic       reset_i,
    input  logic       bus_cs_n_i,
    input  logic       bus_rd_nwr_i,
    input  logic       bus_bytesel_i,
    input  logic [3:0] bus_reg_num_i,
    input  logic [7:0] bus_data_i,
    output logic       write_strobe_o,
    output logic       read_strobe_o,
    output logic [3:0] reg_num_o,
    output logic       bytesel_o,
    output logic [7:0] data_o,
    output logic       cs_active_o
);

    // Synchronized control pins.
    logic cs_n_sync;
    logic rd_sync;
    logic cs_on;

    // Single-flop sample of the address/data pins; only read at COMMIT,
    // when the host is guaranteed to be holding them stable.
    logic [3:0] sample_reg_num;
    logic       sample_bytesel;
    logic [7:0] sample_data;

    bus_state_t                  state;
    logic [BUS_SETTLE_CNT_W-1:0] settle_cnt;

`ifdef BUS_RELEASE_FILTER_EN
    // Set after the first deasserted CS sample seen in WAIT_RELEASE.
    logic release_seen;
`endif

    xosera_sync_ff #(
        .N       (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_cs_sync (
        .clk (clk),
        .rst (reset_i),
        .d   (bus_cs_n_i),
        .q   (cs_n_sync)
    );

    xosera_sync_ff #(
        .N       (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_rd_sync (
        .clk (clk),
        .rst (reset_i),
        .d   (bus_rd_nwr_i),
        .q   (rd_sync)
    );

    assign cs_on = (cs_n_sync == CS_ENABLED);

    // Sample the address/data pins every clock.
    // NOTE: this register is rewritten every clock, but it is still reset so
    // the first COMMIT after reset can never latch an unknown value.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            sample_reg_num <= 4'h0;
            sample_bytesel <= 1'b0;
            sample_data    <= 8'h00;
        end else begin
            sample_reg_num <= bus_reg_num_i;
            sample_bytesel <= bus_bytesel_i;
            sample_data    <= bus_data_i;
        end
    end

    // Access FSM: qualify CS, commit once, then wait for CS to be released.
    // NOTE: every state and output here is written with <= so all of them
    // update together on the edge and none sees another's new value early.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state          <= IDLE;
            settle_cnt     <= '0;
            write_strobe_o <= 1'b0;
            read_strobe_o  <= 1'b0;
            reg_num_o      <= 4'h0;
            bytesel_o      <= 1'b0;
            data_o         <= 8'h00;
            cs_active_o    <= 1'b0;
`ifdef BUS_RELEASE_FILTER_EN
            release_seen   <= 1'b0;
`endif
        end else begin
            // Strobes default low so each one lasts exactly one clock.
            write_strobe_o <= 1'b0;
            read_strobe_o  <= 1'b0;

            case (state)
                IDLE: begin
                    if (cs_on) begin
                        state       <= SETTLE;
                        settle_cnt  <= settle_load(SETTLE_CYCLES);
                        cs_active_o <= 1'b1;
                    end
                end

                SETTLE: begin
                    if (!cs_on) begin
                        // CS dropped before it settled: treat as a glitch.
                        state       <= IDLE;
                        cs_active_o <= 1'b0;
                    end else if (settle_cnt == '0) begin
                        state <= COMMIT;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end

                COMMIT: begin
                    reg_num_o <= sample_reg_num;
                    bytesel_o <= sample_bytesel;
                    data_o    <= sample_data;
                    if (rd_sync == RnW_READ) begin
                        read_strobe_o <= 1'b1;
                    end else begin
                        write_strobe_o <= 1'b1;
                    end
                    state <= WAIT_RELEASE;
`ifdef BUS_RELEASE_FILTER_EN
                    release_seen <= 1'b0;
`endif
                end

                WAIT_RELEASE: begin
`ifdef BUS_RELEASE_FILTER_EN
                    if (!cs_on) begin
                        if (release_seen) begin
                            state        <= IDLE;
                            cs_active_o  <= 1'b0;
                            release_seen <= 1'b0;
                        end else begin
                            release_seen <= 1'b1;
                        end
                    end else begin
                        release_seen <= 1'b0;
                    end
`else
                    if (!cs_on) begin
                        state       <= IDLE;
                        cs_active_o <= 1'b0;
                    end
`endif
                end

                default: begin
                    state       <= IDLE;
                    cs_active_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xosera_bus_sync.sv
// Testbench for xosera_bus_sync. Two instances share the bus pins: one with
// default parameters, one with a deeper synchronizer and longer settle time.
// A plan of CS runs is built up front; a run-level model derives, for every
// clock edge, which strobe each instance should fire and what it latches.
module tb_xosera_bus_sync;

    localparam int MAXE   = 1200;
    localparam int NI     = 2;
    localparam int SYNC_A = 2;
    localparam int SET_A  = 1;
    localparam int SYNC_B = 3;
    localparam int SET_B  = 3;
`ifdef BUS_RELEASE_FILTER_EN
    localparam int REL = 2;
`else
    localparam int REL = 1;
`endif

    logic       clk = 1'b0;
    logic       reset_i;
    logic       cs_n;
    logic       rd_nwr;
    logic       bytesel;
    logic [3:0] reg_num;
    logic [7:0] data;

    logic       wr_a, rd_a, bs_a, act_a;
    logic [3:0] regn_a;
    logic [7:0] dat_a;
    logic       wr_b, rd_b, bs_b, act_b;
    logic [3:0] regn_b;
    logic [7:0] dat_b;

    // Pin plan, one entry per clock edge.
    logic       p_cs  [MAXE];
    logic       p_rd  [MAXE];
    logic       p_bs  [MAXE];
    logic [3:0] p_reg [MAXE];
    logic [7:0] p_dat [MAXE];
    int         n_edges = 0;

    // Expected outputs after each edge, per instance.
    logic       e_wr  [NI][MAXE];
    logic       e_rd  [NI][MAXE];
    logic       e_act [NI][MAXE];
    logic       e_bs  [NI][MAXE];
    logic [3:0] e_reg [NI][MAXE];
    logic [7:0] e_dat [NI][MAXE];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    xosera_bus_sync u_dut_a (
        .clk            (clk),
        .reset_i        (reset_i),
        .bus_cs_n_i     (cs_n),
        .bus_rd_nwr_i   (rd_nwr),
        .bus_bytesel_i  (bytesel),
        .bus_reg_num_i  (reg_num),
        .bus_data_i     (data),
        .write_strobe_o (wr_a),
        .read_strobe_o  (rd_a),
        .reg_num_o      (regn_a),
        .bytesel_o      (bs_a),
        .data_o         (dat_a),
        .cs_active_o    (act_a)
    );

    xosera_bus_sync #(
        .SYNC_STAGES   (SYNC_B),
        .SETTLE_CYCLES (SET_B)
    ) u_dut_b (
        .clk            (clk),
        .reset_i        (reset_i),
        .bus_cs_n_i     (cs_n),
        .bus_rd_nwr_i   (rd_nwr),
        .bus_bytesel_i  (bytesel),
        .bus_reg_num_i  (reg_num),
        .bus_data_i     (data),
        .write_strobe_o (wr_b),
        .read_strobe_o  (rd_b),
        .reg_num_o      (regn_b),
        .bytesel_o      (bs_b),
        .data_o         (dat_b),
        .cs_active_o    (act_b)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Append a CS-low run of low_len edges followed by high_len idle edges.
    task automatic add_run(input int low_len, input int high_len, input logic rd,
                           input logic rd_rand, input logic [3:0] r, input logic bs,
                           input logic [7:0] d);
        for (int k = 0; k < low_len + high_len; k++) begin
            if (n_edges < MAXE) begin
                p_cs[n_edges]  = (k >= low_len);
                p_rd[n_edges]  = rd_rand ? 1'($urandom_range(0, 1)) : rd;
                p_reg[n_edges] = r;
                p_bs[n_edges]  = bs;
                p_dat[n_edges] = d;
                n_edges++;
            end
        end
    endtask

    task automatic mark_active(input int inst, input int from, input int upto);
        for (int n = from; n <= upto && n < n_edges; n++) e_act[inst][n] = 1'b1;
    endtask

    // Run-level model: a low run shorter than sc+1 samples is a glitch; a
    // longer one commits once, strobing s+sc+1 edges after its first sample,
    // and is released by REL consecutive high samples after COMMIT.
    task automatic build_expected(input int inst, input int s, input int sc);
        int idx, e0, len, es, smp, u, run;
        for (int n = 0; n < MAXE; n++) begin
            e_wr[inst][n]  = 1'b0;
            e_rd[inst][n]  = 1'b0;
            e_act[inst][n] = 1'b0;
            e_bs[inst][n]  = 1'b0;
            e_reg[inst][n] = 4'h0;
            e_dat[inst][n] = 8'h00;
        end
        idx = 0;
        while (idx < n_edges) begin
            e0 = idx;
            while (e0 < n_edges && p_cs[e0]) e0++;
            if (e0 >= n_edges) break;
            len = 0;
            while (e0 + len < n_edges && !p_cs[e0 + len]) len++;
            if (len <= sc) begin
                mark_active(inst, e0 + s, e0 + len + s - 1);
                idx = e0 + len + 1;
            end else begin
                smp = e0 + s + sc;
                es  = smp + 1;
                if (es < n_edges) begin
                    if (p_rd[e0 + sc + 1]) e_rd[inst][es] = 1'b1;
                    else                   e_wr[inst][es] = 1'b1;
                    for (int n = es; n < n_edges; n++) begin
                        e_reg[inst][n] = p_reg[smp];
                        e_bs[inst][n]  = p_bs[smp];
                        e_dat[inst][n] = p_dat[smp];
                    end
                end
                u   = e0 + sc + 2;
                run = 0;
                while (u < n_edges) begin
                    if (p_cs[u]) run++;
                    else         run = 0;
                    if (run == REL) break;
                    u++;
                end
                mark_active(inst, e0 + s, u + s - 1);
                idx = u + 1;
            end
        end
    endtask

    task automatic build_plan();
        add_run(0, 4, 1'b1, 1'b0, 4'h0, 1'b0, 8'h00);
        add_run(10, 4, 1'b0, 1'b0, 4'h3, 1'b1, 8'hA5);   // write
        add_run(10, 4, 1'b1, 1'b0, 4'hC, 1'b0, 8'h00);   // read
        add_run(2, 4, 1'b0, 1'b0, 4'h7, 1'b0, 8'h5A);    // glitch for the slow instance
        add_run(1, 4, 1'b0, 1'b0, 4'h8, 1'b1, 8'h66);    // glitch for both
        add_run(6, 2, 1'b0, 1'b0, 4'h1, 1'b0, 8'h11);    // back-to-back writes
        add_run(6, 4, 1'b0, 1'b0, 4'h2, 1'b0, 8'h22);
        add_run(10, 1, 1'b0, 1'b0, 4'h9, 1'b1, 8'h99);   // one-sample release glitch
        add_run(10, 3, 1'b0, 1'b0, 4'hA, 1'b0, 8'hAA);
        add_run(8, 6, 1'b0, 1'b0, 4'hB, 1'b1, 8'hBB);
        for (int i = 0; i < 40; i++) begin
            add_run($urandom_range(1, 16), $urandom_range(1, 6), 1'b0, 1'b1,
                    4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    8'($urandom_range(0, 255)));
        end
        add_run(0, 16, 1'b1, 1'b0, 4'h0, 1'b0, 8'h00);
    endtask

    task automatic check_edge(input int n);
        check($sformatf("wr_a@%0d", n),   8'(wr_a),   8'(e_wr[0][n]));
        check($sformatf("rd_a@%0d", n),   8'(rd_a),   8'(e_rd[0][n]));
        check($sformatf("act_a@%0d", n),  8'(act_a),  8'(e_act[0][n]));
        check($sformatf("reg_a@%0d", n),  8'(regn_a), 8'(e_reg[0][n]));
        check($sformatf("bs_a@%0d", n),   8'(bs_a),   8'(e_bs[0][n]));
        check($sformatf("data_a@%0d", n), dat_a,      e_dat[0][n]);
        check($sformatf("wr_b@%0d", n),   8'(wr_b),   8'(e_wr[1][n]));
        check($sformatf("rd_b@%0d", n),   8'(rd_b),   8'(e_rd[1][n]));
        check($sformatf("act_b@%0d", n),  8'(act_b),  8'(e_act[1][n]));
        check($sformatf("reg_b@%0d", n),  8'(regn_b), 8'(e_reg[1][n]));
        check($sformatf("bs_b@%0d", n),   8'(bs_b),   8'(e_bs[1][n]));
        check($sformatf("data_b@%0d", n), dat_b,      e_dat[1][n]);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_a"},  8'(wr_a),   8'h00);
        check({tag, "_rd_a"},  8'(rd_a),   8'h00);
        check({tag, "_act_a"}, 8'(act_a),  8'h00);
        check({tag, "_reg_a"}, 8'(regn_a), 8'h00);
        check({tag, "_bs_a"},  8'(bs_a),   8'h00);
        check({tag, "_dat_a"}, dat_a,      8'h00);
        check({tag, "_wr_b"},  8'(wr_b),   8'h00);
        check({tag, "_rd_b"},  8'(rd_b),   8'h00);
        check({tag, "_act_b"}, 8'(act_b),  8'h00);
        check({tag, "_reg_b"}, 8'(regn_b), 8'h00);
        check({tag, "_bs_b"},  8'(bs_b),   8'h00);
        check({tag, "_dat_b"}, dat_b,      8'h00);
    endtask

    initial begin
        reset_i = 1'b1;
        cs_n    = 1'b1;
        rd_nwr  = 1'b1;
        bytesel = 1'b0;
        reg_num = 4'h0;
        data    = 8'h00;

        build_plan();
        build_expected(0, SYNC_A, SET_A);
        build_expected(1, SYNC_B, SET_B);

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        reset_i = 1'b0;

        // Planned stimulus, one plan entry per edge, checked after every edge.
        for (int n = 0; n < n_edges; n++) begin
            cs_n    = p_cs[n];
            rd_nwr  = p_rd[n];
            bytesel = p_bs[n];
            reg_num = p_reg[n];
            data    = p_dat[n];
            @(posedge clk);
            @(negedge clk);
            check_edge(n);
        end

        // Reset asserted during WAIT_RELEASE, released with CS still low.
        cs_n    = 1'b0;
        rd_nwr  = 1'b0;
        bytesel = 1'b1;
        reg_num = 4'h5;
        data    = 8'h3C;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("pre_rst_act_a", 8'(act_a), 8'h01);
        check("pre_rst_reg_a", 8'(regn_a), 8'h05);
        check("pre_rst_dat_b", dat_b, 8'h3C);
        #2 reset_i = 1'b1;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        reset_i = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("post_rst_wr_a@%0d", k), 8'(wr_a), 8'((k == SYNC_A + SET_A + 1) ? 1 : 0));
            check($sformatf("post_rst_wr_b@%0d", k), 8'(wr_b), 8'((k == SYNC_B + SET_B + 1) ? 1 : 0));
            check($sformatf("post_rst_rd_a@%0d", k), 8'(rd_a), 8'h00);
            if (k == SYNC_A + SET_A + 1) begin
                check("post_rst_reg_a", 8'(regn_a), 8'h05);
                check("post_rst_dat_a", dat_a, 8'h3C);
            end
        end
        cs_n = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("final_act_a", 8'(act_a), 8'h00);
        check("final_act_b", 8'(act_b), 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
